wdt_timer: RTL and testbench

//  Watchdog timer that produces the level 'timeout' consumed by the CSR unit.
//  The CSR unit uses it as the machine timer-interrupt pending bit (mip.MTIP)
//  and as the core soft-reset request.

---
 rtl/wdt_pkg.sv | 17 +
 rtl/wdt_timer_if.sv | 30 +++
 rtl/wdt_prescaler.sv | 29 ++
 rtl/wdt_timer.sv | 99 +++++++++
 tb/tb_wdt_timer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/wdt_pkg.sv
// Shared types and register map for the watchdog timer.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPIRED
  } wdt_state_e;

  typedef logic [1:0] wdt_addr_t;

  localparam wdt_addr_t WDT_WDEN   = 2'd0;
  localparam wdt_addr_t WDT_WDLIVE = 2'd1;
  localparam wdt_addr_t WDT_WTOCNT = 2'd2;
  localparam wdt_addr_t WDT_WDCNT  = 2'd3;

endpackage

// File: rtl/wdt_timer_if.sv
// Register port between the bus bridge (master) and the watchdog (slave).
interface wdt_timer_if
  import wdt_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             reg_we;
  wdt_addr_t        reg_addr;
  logic [CNT_W-1:0] reg_wdata;
  logic [CNT_W-1:0] reg_rdata;
  logic             timeout;

  modport master (
    output reg_we,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata,
    input  timeout
  );

  modport slave (
    input  reg_we,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata,
    output timeout
  );

endinterface

// File: rtl/wdt_prescaler.sv
// Divides clk into counter ticks; one tick per PRESCALE enabled cycles.
module wdt_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;

  assign tick_o = en_i && (presc_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (clr_i) begin
      presc_q <= '0;
    end else if (en_i) begin
      presc_q <= tick_o ? '0 : presc_q + PW'(1);
    end
  end

endmodule

// File: rtl/wdt_timer.sv
// Watchdog: counts ticks while enabled, raises a held timeout at threshold.
module wdt_timer
  import wdt_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  wdt_timer_if.slave bus
);

  wdt_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] wtocnt_q;
  logic             wden_q;
  logic             timeout_q;

  logic wr_en;
  logic wr_live;
  logic wr_toc;
  logic enable_w;
  logic disable_w;
  logic kick_w;
  logic count_en;
  logic tick;

  assign wr_en     = bus.reg_we && (bus.reg_addr == WDT_WDEN);
  assign wr_live   = bus.reg_we && (bus.reg_addr == WDT_WDLIVE);
  assign wr_toc    = bus.reg_we && (bus.reg_addr == WDT_WTOCNT);
  assign enable_w  = wr_en && bus.reg_wdata[0] && (state_q == IDLE);
  assign disable_w = wr_en && !bus.reg_wdata[0];
  assign kick_w    = wr_live && bus.reg_wdata[0] && (state_q != IDLE);
  assign count_en  = (state_q == COUNT);

  generate
    if (PRESCALE > 1) begin : g_presc
      wdt_prescaler #(
        .PRESCALE(PRESCALE)
      ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en_i  (count_en),
        .clr_i (enable_w || disable_w || kick_w),
        .tick_o(tick)
      );
    end else begin : g_nopresc
      assign tick = count_en;
    end
  endgenerate

  // Saturating next count; expiry is judged on the value being stored.
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wtocnt_q  <= '0;
      wden_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (wr_toc) wtocnt_q <= bus.reg_wdata;
      if (wr_en)  wden_q   <= bus.reg_wdata[0];
      if (disable_w) begin
        state_q   <= IDLE;
        timeout_q <= 1'b0;
        cnt_q     <= '0;
      end else if (enable_w) begin
        state_q <= COUNT;
        cnt_q   <= '0;
      end else if (kick_w) begin
        state_q   <= COUNT;
        timeout_q <= 1'b0;
        cnt_q     <= '0;
      end else if (count_en) begin
        cnt_q <= cnt_d;
        if (cnt_d >= wtocnt_q) begin
          state_q   <= EXPIRED;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      WDT_WDEN:   bus.reg_rdata = {{(CNT_W-1){1'b0}}, wden_q};
      WDT_WTOCNT: bus.reg_rdata = wtocnt_q;
      WDT_WDCNT:  bus.reg_rdata = cnt_q;
      default:    bus.reg_rdata = '0;
    endcase
  end

  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_wdt_timer.sv
// Directed scoreboard bench for wdt_timer at PRESCALE 1 and 4.
module tb_wdt_timer;
  import wdt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wdt_timer_if #(.CNT_W(32)) bus0 ();
  wdt_timer_if #(.CNT_W(32)) bus1 ();

  wdt_timer #(.CNT_W(32), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  wdt_timer #(.CNT_W(32), .PRESCALE(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  typedef struct {
    bit          sel;
    string       name;
    logic [31:0] rd;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic drv(bit sel, logic we, logic [1:0] a, logic [31:0] d);
    if (sel) begin
      bus1.reg_we = we; bus1.reg_addr = a; bus1.reg_wdata = d;
    end else begin
      bus0.reg_we = we; bus0.reg_addr = a; bus0.reg_wdata = d;
    end
  endtask

  task automatic wr(bit sel, logic [1:0] a, logic [31:0] d);
    drv(sel, 1'b1, a, d);
    @(posedge clk); #1;
    drv(sel, 1'b0, a, 32'd0);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(bit sel, string nm, logic [1:0] a,
                     logic [31:0] rd, logic to);
    exp_t e;
    drv(sel, 1'b0, a, 32'd0);
    e.sel = sel; e.name = nm; e.rd = rd; e.to = to;
    sb.push_back(e);
    @(negedge clk); #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] rd;
    logic        to;
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      rd = e.sel ? bus1.reg_rdata : bus0.reg_rdata;
      to = e.sel ? bus1.timeout : bus0.timeout;
      n_cmp++;
      if (rd !== e.rd || to !== e.to) begin
        n_bad++;
        $display("FAIL %s: rdata=%0d timeout=%0b, want rdata=%0d timeout=%0b",
                 e.name, rd, to, e.rd, e.to);
      end
    end
  end

  initial begin
    drv(0, 1'b0, 2'd0, 32'd0);
    drv(1, 1'b0, 2'd0, 32'd0);

    chk(0, "rst_wden", WDT_WDEN, 0, 0);
    chk(0, "rst_wdlive", WDT_WDLIVE, 0, 0);
    chk(0, "rst_wtocnt", WDT_WTOCNT, 0, 0);
    chk(0, "rst_wdcnt", WDT_WDCNT, 0, 0);
    chk(1, "rst_wdcnt_p4", WDT_WDCNT, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic expiry at threshold 5
    wr(0, WDT_WTOCNT, 5);
    wr(0, WDT_WDEN, 1);
    chk(0, "t1_en", WDT_WDCNT, 0, 0);
    idle(4);
    chk(0, "t1_cnt4", WDT_WDCNT, 4, 0);
    idle(1);
    chk(0, "t1_expire", WDT_WDCNT, 5, 1);
    idle(20);
    chk(0, "t1_hold", WDT_WDCNT, 5, 1);

    // recover from expiry with a kick
    wr(0, WDT_WTOCNT, 10);
    chk(0, "t3_wtocnt", WDT_WTOCNT, 10, 1);
    wr(0, WDT_WDLIVE, 1);
    chk(0, "t3_kick", WDT_WDCNT, 0, 0);
    idle(9);
    chk(0, "t3_cnt9", WDT_WDCNT, 9, 0);
    idle(1);
    chk(0, "t3_reexp", WDT_WDCNT, 10, 1);
    chk(0, "t3_wden_rd", WDT_WDEN, 1, 1);
    chk(0, "t3_wdlive_rd", WDT_WDLIVE, 0, 1);

    // periodic kicks keep it alive
    wr(0, WDT_WDLIVE, 1);
    for (int i = 0; i < 12; i++) begin
      idle(7);
      chk(0, "t2_alive", WDT_WDCNT, 7, 0);
      wr(0, WDT_WDLIVE, 1);
    end
    wr(0, WDT_WDLIVE, 0);
    chk(0, "t2_nop_kick", WDT_WDCNT, 1, 0);
    wr(0, WDT_WDLIVE, 1);

    // kick on the expiry edge wins
    idle(9);
    chk(0, "t5_cnt9", WDT_WDCNT, 9, 0);
    wr(0, WDT_WDLIVE, 1);
    chk(0, "t5_kick_wins", WDT_WDCNT, 0, 0);

    // threshold 0 while counting: old value used this edge, expire next
    wr(0, WDT_WTOCNT, 0);
    chk(0, "t5_toc0_old", WDT_WDCNT, 1, 0);
    idle(1);
    chk(0, "t5_toc0_exp", WDT_WDCNT, 2, 1);

    wr(0, WDT_WDEN, 0);
    chk(0, "dis_cnt", WDT_WDCNT, 0, 0);
    chk(0, "dis_wden", WDT_WDEN, 0, 0);

    // async reset mid-count
    wr(0, WDT_WTOCNT, 100);
    wr(0, WDT_WDEN, 1);
    idle(5);
    #2 rst = 1'b1;
    chk(0, "t6_rst_cnt", WDT_WDCNT, 0, 0);
    chk(0, "t6_rst_toc", WDT_WTOCNT, 0, 0);
    chk(0, "t6_rst_wden", WDT_WDEN, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    chk(0, "t6_no_count", WDT_WDCNT, 0, 0);

    // async reset while expired
    wr(0, WDT_WTOCNT, 2);
    wr(0, WDT_WDEN, 1);
    idle(2);
    chk(0, "t6_exp", WDT_WDCNT, 2, 1);
    idle(1);
    #2 rst = 1'b1;
    chk(0, "t6_exp_rst", WDT_WDCNT, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wr(0, WDT_WTOCNT, 3);
    wr(0, WDT_WDEN, 1);
    idle(3);
    chk(0, "t6_rearm", WDT_WDCNT, 3, 1);

    // prescaler of 4, threshold 3
    wr(1, WDT_WTOCNT, 3);
    wr(1, WDT_WDEN, 1);
    idle(11);
    chk(1, "t4_pre11", WDT_WDCNT, 2, 0);
    idle(1);
    chk(1, "t4_exp12", WDT_WDCNT, 3, 1);
    wr(1, WDT_WDEN, 0);
    chk(1, "t4_dis", WDT_WDCNT, 0, 0);
    wr(1, WDT_WDEN, 1);
    idle(6);
    chk(1, "t4_mid", WDT_WDCNT, 1, 0);
    wr(1, WDT_WDEN, 0);
    chk(1, "t4_mid_dis", WDT_WDCNT, 0, 0);
    idle(20);
    chk(1, "t4_idle", WDT_WDCNT, 0, 0);
    wr(1, WDT_WDEN, 1);
    idle(3);
    chk(1, "t4_presc_clr", WDT_WDCNT, 0, 0);
    idle(1);
    chk(1, "t4_tick", WDT_WDCNT, 1, 0);

    @(negedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: left=%0d, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
